// File: rtl/mips_multicycle_if.sv
// Memory bus between the multicycle core and its unified instruction/data memory.
// The core holds req/we/addr/wdata stable until the memory answers with ready.
interface mips_multicycle_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output req, we, addr, wdata, input rdata, ready);
    modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one ALU and one memory port shared across FETCH/DECODE/EXEC/MEM/WB.
// Halts on illegal opcodes and counts retired instructions (saturating).
module mips_multicycle #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input  logic                clock,
    input  logic                reset,
    mips_multicycle_if.master   mem,
    output logic [ADDR_W-1:0]   pc,
    output logic [31:0]         ula_result,
    output logic [31:0]         data_mem,
    output logic                halted,
    output logic [CNT_W-1:0]    instr_count
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [31:0]       regs [32];
    logic [31:0]       ir;
    logic [31:0]       a;
    logic [31:0]       b;
    logic [ADDR_W-1:0] pc_plus4;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        dest;
    logic [31:0]       sext;
    logic [31:0]       alu_out;
    logic [31:0]       pc4_wide;
    logic [31:0]       jump_wide;
    logic [31:0]       br_off;
    logic [ADDR_W-1:0] branch_target;
    logic              legal;
    logic              xfer;
    logic              retire;

    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];
    assign rs        = ir[25:21];
    assign rt        = ir[20:16];
    assign dest      = (opcode == OP_RTYPE) ? ir[15:11] : ir[20:16];
    assign sext      = {{16{ir[15]}}, ir[15:0]};
    assign br_off    = {sext[29:0], 2'b00};
    assign pc4_wide  = 32'(pc_plus4);
    assign jump_wide = (pc4_wide & 32'hF000_0000) | {4'b0000, ir[25:0], 2'b00};
    assign branch_target = pc_plus4 + br_off[ADDR_W-1:0];
    assign xfer      = mem.req && mem.ready;

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_RTYPE: legal = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                              (funct == 6'h25) || (funct == 6'h2A);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_out = a + sext;
        if (opcode == OP_RTYPE) begin
            case (funct)
                6'h20:   alu_out = a + b;
                6'h22:   alu_out = a - b;
                6'h24:   alu_out = a & b;
                6'h25:   alu_out = a | b;
                6'h2A:   alu_out = {31'd0, $signed(a) < $signed(b)};
                default: alu_out = a + b;
            endcase
        end
    end

    // Next state, plus the strobe marking each instruction's final state-exit.
    always_comb begin
        state_next = state;
        retire     = 1'b0;
        unique case (state)
            S_FETCH:  if (xfer) state_next = S_DECODE;
            S_DECODE: state_next = legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI: state_next = S_WB;
                    OP_LW, OP_SW:      state_next = S_MEM;
                    OP_BEQ, OP_J: begin
                        state_next = S_FETCH;
                        retire     = 1'b1;
                    end
                    default:           state_next = S_HALT;
                endcase
            end
            S_MEM: begin
                if (xfer) begin
                    state_next = (opcode == OP_LW) ? S_WB : S_FETCH;
                    retire     = (opcode != OP_LW);
                end
            end
            S_WB: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            pc_plus4    <= '0;
            ir          <= '0;
            a           <= '0;
            b           <= '0;
            ula_result  <= '0;
            data_mem    <= '0;
            halted      <= 1'b0;
            instr_count <= '0;
            mem.req     <= 1'b0;
            mem.we      <= 1'b0;
            mem.addr    <= '0;
            mem.wdata   <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            if (retire && (instr_count != {CNT_W{1'b1}})) instr_count <= instr_count + 1'b1;
            case (state)
                // FETCH spends its entry cycle idle, which also guarantees the gap between transfers.
                S_FETCH: begin
                    if (!mem.req) begin
                        mem.req  <= 1'b1;
                        mem.we   <= 1'b0;
                        mem.addr <= pc;
                    end else if (mem.ready) begin
                        mem.req  <= 1'b0;
                        ir       <= mem.rdata;
                        pc_plus4 <= pc + ADDR_W'(4);
                    end
                end
                S_DECODE: begin
                    a <= (rs == 5'd0) ? 32'd0 : regs[rs];
                    b <= (rt == 5'd0) ? 32'd0 : regs[rt];
                    if (!legal) halted <= 1'b1;
                end
                S_EXEC: begin
                    case (opcode)
                        OP_RTYPE, OP_ADDI: ula_result <= alu_out;
                        OP_LW, OP_SW: begin
                            ula_result <= alu_out;
                            mem.req    <= 1'b1;
                            mem.we     <= (opcode == OP_SW);
                            mem.addr   <= alu_out[ADDR_W-1:0];
                            mem.wdata  <= b;
                        end
                        OP_BEQ:  pc <= (a == b) ? branch_target : pc_plus4;
                        OP_J:    pc <= jump_wide[ADDR_W-1:0];
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem.ready) begin
                        mem.req <= 1'b0;
                        if (opcode == OP_LW) data_mem <= mem.rdata;
                        else                 pc       <= pc_plus4;
                    end
                end
                S_WB: begin
                    if (dest != 5'd0) regs[dest] <= (opcode == OP_LW) ? data_mem : ula_result;
                    pc <= pc_plus4;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: two instances (16-bit and 8-bit address) each
// driven by a small variable-latency memory model; expected values are hand-computed.
module tb_mips_multicycle;
    logic clock = 1'b0;
    logic reset_a;
    logic reset_b;
    int   checks = 0;
    int   errors = 0;
    int   edges;

    always #5 clock = ~clock;

    mips_multicycle_if #(.ADDR_W(16)) bus_a ();
    mips_multicycle_if #(.ADDR_W(8))  bus_b ();

    logic [15:0] pc_a;
    logic [31:0] ula_a;
    logic [31:0] dmem_a;
    logic        halted_a;
    logic [15:0] count_a;
    logic [7:0]  pc_b;
    logic [31:0] ula_b;
    logic [31:0] dmem_b;
    logic        halted_b;
    logic [1:0]  count_b;

    mips_multicycle #(.ADDR_W(16), .RESET_PC(16'h0040), .CNT_W(16)) dut_a (
        .clock(clock), .reset(reset_a), .mem(bus_a), .pc(pc_a), .ula_result(ula_a),
        .data_mem(dmem_a), .halted(halted_a), .instr_count(count_a)
    );

    mips_multicycle #(.ADDR_W(8), .RESET_PC(8'hF0), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset_b), .mem(bus_b), .pc(pc_b), .ula_result(ula_b),
        .data_mem(dmem_b), .halted(halted_b), .instr_count(count_b)
    );

    // Memory models: ready rises after wait_* idle request cycles; writes commit on the ready edge.
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:63];
    int wait_a = 0;
    int wait_b = 0;
    int cnt_a  = 0;
    int cnt_b  = 0;

    assign bus_a.ready = bus_a.req && (cnt_a == wait_a);
    assign bus_a.rdata = mem_a[bus_a.addr[11:2]];
    assign bus_b.ready = bus_b.req && (cnt_b == wait_b);
    assign bus_b.rdata = mem_b[bus_b.addr[7:2]];

    always @(posedge clock) begin
        if (bus_a.req && !bus_a.ready) cnt_a <= cnt_a + 1;
        else                           cnt_a <= 0;
        if (bus_a.req && bus_a.ready && bus_a.we) mem_a[bus_a.addr[11:2]] <= bus_a.wdata;
        if (bus_b.req && !bus_b.ready) cnt_b <= cnt_b + 1;
        else                           cnt_b <= 0;
        if (bus_b.req && bus_b.ready && bus_b.we) mem_b[bus_b.addr[7:2]] <= bus_b.wdata;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic clear_a();
        for (int i = 0; i < 1024; i++) mem_a[i] <= 32'd0;
    endtask

    task automatic load_a(input logic [15:0] addr, input logic [31:0] word);
        mem_a[addr[11:2]] <= word;
    endtask

    task automatic wait_halt_a(input int limit, output int n);
        n = 0;
        while (!halted_a && n < limit) begin
            tick(1);
            n++;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        wait_a  = 0;
        wait_b  = 0;

        // Phase 1: full instruction mix, zero-wait memory.
        clear_a();
        load_a(16'h0040, 32'h20010005);  // addi $1,$0,5
        load_a(16'h0044, 32'h20020007);  // addi $2,$0,7
        load_a(16'h0048, 32'h00221820);  // add  $3,$1,$2
        load_a(16'h004C, 32'hAC030100);  // sw   $3,0x100($0)
        load_a(16'h0050, 32'h8C040100);  // lw   $4,0x100($0)
        load_a(16'h0054, 32'h00222822);  // sub  $5,$1,$2
        load_a(16'h0058, 32'h00A1302A);  // slt  $6,$5,$1
        load_a(16'h005C, 32'h00623824);  // and  $7,$3,$2
        load_a(16'h0060, 32'h00624025);  // or   $8,$3,$2
        load_a(16'h0064, 32'h20000009);  // addi $0,$0,9
        load_a(16'h0068, 32'h10220005);  // beq  $1,$2,+5 (not taken)
        load_a(16'h006C, 32'h10210001);  // beq  $1,$1,+1 (taken)
        load_a(16'h0070, 32'h20090001);  // addi $9,$0,1 (skipped)
        load_a(16'h0074, 32'h08000020);  // j    0x80
        load_a(16'h0080, 32'hAC050200);
        load_a(16'h0084, 32'hAC060204);
        load_a(16'h0088, 32'hAC070208);
        load_a(16'h008C, 32'hAC08020C);
        load_a(16'h0090, 32'hAC000210);
        load_a(16'h0094, 32'hAC040214);
        load_a(16'h0098, 32'hAC090218);
        load_a(16'h009C, 32'hFC000000);  // illegal opcode 0x3F
        load_a(16'h0210, 32'hDEADBEEF);
        load_a(16'h0218, 32'hDEADBEEF);

        tick(1);
        check_output("rst_req", bus_a.req, 0);
        check_output("rst_we", bus_a.we, 0);
        check_output("rst_addr", bus_a.addr, 0);
        check_output("rst_wdata", bus_a.wdata, 0);
        check_output("rst_pc", pc_a, 32'h40);
        check_output("rst_ula", ula_a, 0);
        check_output("rst_dmem", dmem_a, 0);
        check_output("rst_halted", halted_a, 0);
        check_output("rst_count", count_a, 0);
        reset_a = 1'b0;

        tick(1);
        check_output("first_req", bus_a.req, 1);
        check_output("first_addr", bus_a.addr, 32'h40);
        check_output("first_we", bus_a.we, 0);
        tick(24);
        check_output("count_e25", count_a, 4);
        tick(1);
        check_output("count_e26", count_a, 5);
        check_output("dmem_lw", dmem_a, 12);
        check_output("mem_100", mem_a[64], 12);
        check_output("pc_after_lw", pc_a, 32'h54);
        check_output("ula_lw", ula_a, 32'h100);

        wait_halt_a(200, edges);
        check_output("halt_cycles", edges, 75);
        check_output("halted", halted_a, 1);
        check_output("count_halt", count_a, 20);
        check_output("pc_halt", pc_a, 32'h9C);
        check_output("ula_halt", ula_a, 32'h218);
        check_output("mem_sub", mem_a[128], 32'hFFFFFFFE);
        check_output("mem_slt", mem_a[129], 1);
        check_output("mem_and", mem_a[130], 4);
        check_output("mem_or", mem_a[131], 15);
        check_output("mem_r0", mem_a[132], 0);
        check_output("mem_r4", mem_a[133], 12);
        check_output("mem_skip", mem_a[134], 0);
        tick(3);
        check_output("halt_req", bus_a.req, 0);
        check_output("halt_pc_frozen", pc_a, 32'h9C);
        check_output("halt_count_frozen", count_a, 20);

        // Phase 2: three wait cycles on every request.
        reset_a = 1'b1;
        wait_a  = 3;
        clear_a();
        load_a(16'h0040, 32'h20010005);
        load_a(16'h0044, 32'h20020007);
        load_a(16'h0048, 32'h00221820);
        load_a(16'h004C, 32'hAC030100);
        load_a(16'h0050, 32'h8C040100);
        load_a(16'h0054, 32'hFC000000);
        tick(1);
        check_output("rst2_halted", halted_a, 0);
        reset_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check_output("wait_fetch_req", bus_a.req, 1);
            check_output("wait_fetch_addr", bus_a.addr, 32'h40);
        end
        tick(1);
        check_output("wait_fetch_done", bus_a.req, 0);
        tick(26);
        for (int i = 0; i < 4; i++) begin
            check_output("sw_req", bus_a.req, 1);
            check_output("sw_we", bus_a.we, 1);
            check_output("sw_addr", bus_a.addr, 32'h100);
            check_output("sw_wdata", bus_a.wdata, 12);
            tick(1);
        end
        check_output("sw_done_req", bus_a.req, 0);
        check_output("count_e35", count_a, 4);
        tick(11);
        check_output("count_e46", count_a, 4);
        tick(1);
        check_output("count_e47", count_a, 5);
        check_output("dmem_wait", dmem_a, 12);
        check_output("mem_100_wait", mem_a[64], 12);

        // Reset while a fetch is still waiting for ready.
        tick(2);
        check_output("pending_req", bus_a.req, 1);
        reset_a = 1'b1;
        wait_a  = 0;
        clear_a();
        load_a(16'h0040, 32'hAC030300);  // sw $3,0x300($0)
        load_a(16'h0044, 32'hFC000000);
        load_a(16'h0300, 32'hDEADBEEF);
        tick(1);
        check_output("abort_req", bus_a.req, 0);
        check_output("abort_pc", pc_a, 32'h40);
        check_output("abort_count", count_a, 0);
        check_output("abort_dmem", dmem_a, 0);
        check_output("abort_ula", ula_a, 0);
        reset_a = 1'b0;
        wait_halt_a(100, edges);
        check_output("abort_halt_cycles", edges, 8);
        check_output("regs_cleared", mem_a[192], 0);
        check_output("abort_count_end", count_a, 1);

        // Phase 3: 8-bit addresses, 2-bit saturating counter.
        for (int i = 0; i < 64; i++) mem_b[i] <= 32'd0;
        mem_b[60] <= 32'h20010003;  // 0xF0 addi $1,$0,3
        mem_b[61] <= 32'h20020004;  // 0xF4 addi $2,$0,4
        mem_b[62] <= 32'h10220010;  // 0xF8 beq  $1,$2,+16 (not taken)
        mem_b[63] <= 32'h00221820;  // 0xFC add  $3,$1,$2
        mem_b[0]  <= 32'hAC030010;  // 0x00 sw   $3,0x10($0)
        mem_b[1]  <= 32'h1000FFFD;  // 0x04 beq  $0,$0,-3 -> 0xFC
        tick(1);
        check_output("b_rst_pc", pc_b, 32'hF0);
        check_output("b_rst_count", count_b, 0);
        reset_b = 1'b0;
        tick(5);
        check_output("b_count1", count_b, 1);
        tick(5);
        check_output("b_count2", count_b, 2);
        tick(4);
        check_output("b_count3", count_b, 3);
        check_output("b_pc_fc", pc_b, 32'hFC);
        tick(5);
        check_output("b_count_sat", count_b, 3);
        check_output("b_pc_wrap", pc_b, 32'h00);
        check_output("b_ula_add", ula_b, 7);
        tick(5);
        check_output("b_pc_sw", pc_b, 32'h04);
        check_output("b_mem_10", mem_b[4], 7);
        tick(1);
        check_output("b_fetch_req", bus_b.req, 1);
        check_output("b_fetch_addr", bus_b.addr, 32'h04);
        tick(3);
        check_output("b_neg_wrap", pc_b, 32'hFC);
        check_output("b_count_final", count_b, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
